// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: operand sequencer and result collector for one DSP48A1 slice
// used as an unsigned multiply-accumulate engine. It issues one A*B pair per
// accepted handshake and drives OPMODE one cycle behind each issue, so that
// OPMODE lines up with the slice's internal pipeline. After the last pair
// drains through the slice, it captures P/CARRYOUT and pulses done.
module dsp_mac_seq #(
  parameter int LEN_W  = 8,
  parameter int OP_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             sub,
  input  logic             bias_en,
  input  logic [47:0]      bias,
  input  logic             in_valid,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic             in_ready,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [47:0]      dsp_c,
  output logic [17:0]      dsp_d,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p,
  input  logic             dsp_carryout,
  output logic             busy,
  output logic [47:0]      result,
  output logic             carry,
  output logic             done
);

  localparam int DW = $clog2(OP_LAT + 1);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [DW-1:0]    DRAIN_END = DW'(OP_LAT - 1);
  localparam logic [7:0]       OPM_HOLD  = 8'h08;  // X=0, Z=P: P keeps its value

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic             sub_q;
  logic             bias_en_q;
  logic             first_q;
  logic [DW-1:0]    drain_cnt;
  logic             rst_q;
  logic [7:0]       opmode_nxt;
  logic             accept;
  logic             last_accept;
  logic             drain_last;
  logic             start_job;
  logic             start_empty;

  // OPMODE for an issued pair. The first pair seeds Z from 0 or C so any P
  // left over from a previous job is discarded; later pairs accumulate on P.
  // Bit 7 turns the post-adder into Z - X.
  function automatic logic [7:0] issue_opmode(input logic first, input logic sb,
                                               input logic be);
    logic [1:0] zsel;
    zsel = first ? (be ? 2'b11 : 2'b00) : 2'b10;
    return {sb, 3'b000, zsel, 2'b01};
  endfunction

  assign start_job   = (state == IDLE) && start && (len != '0);
  assign start_empty = (state == IDLE) && start && (len == '0);
  assign accept      = (state == RUN) && in_valid;
  assign last_accept = accept && (count == len_q - LEN_ONE);
  assign drain_last  = (state == DRAIN) && (drain_cnt == DRAIN_END);

  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign dsp_d    = 18'd0;
  assign dsp_ce   = 1'b1;
  assign dsp_rst  = rst_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and the OPMODE to register for the following cycle.
  always_comb begin
    state_nxt  = state;
    opmode_nxt = 8'h00;
    case (state)
      IDLE: begin
        if (start_empty)    state_nxt = DONE;
        else if (start_job) state_nxt = RUN;
      end
      RUN: begin
        opmode_nxt = OPM_HOLD;
        if (accept) begin
          opmode_nxt = issue_opmode(first_q, sub_q, bias_en_q);
          if (last_accept) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        opmode_nxt = OPM_HOLD;
        if (drain_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job parameters, pair counter and drain timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      sub_q     <= 1'b0;
      bias_en_q <= 1'b0;
      first_q   <= 1'b0;
      count     <= '0;
      drain_cnt <= '0;
    end else begin
      if (start_job) begin
        len_q     <= len;
        sub_q     <= sub;
        bias_en_q <= bias_en;
        first_q   <= 1'b1;
        count     <= '0;
      end else if (accept) begin
        count   <= count + LEN_ONE;
        first_q <= 1'b0;
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
      else                drain_cnt <= '0;
    end
  end

  // Slice operand stage: A/B/C and the registered OPMODE (stage 0 of the MAC).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_a      <= 18'd0;
      dsp_b      <= 18'd0;
      dsp_c      <= 48'd0;
      dsp_opmode <= 8'h00;
    end else begin
      if (start_job) dsp_c <= bias;
      if (accept) begin
        dsp_a <= in_a;
        dsp_b <= in_b;
      end
      dsp_opmode <= opmode_nxt;
    end
  end

  // Result capture at the end of the slice pipeline (last DRAIN cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= 48'd0;
      carry  <= 1'b0;
    end else if (start_empty) begin
      result <= 48'd0;
      carry  <= 1'b0;
    end else if (drain_last) begin
      result <= dsp_p;
      carry  <= dsp_carryout;
    end
  end

  // Slice reset: held through rst and one clock past its release so the
  // slice's synchronous pipeline registers are cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_q <= 1'b1;
    else     rst_q <= 1'b0;
  end

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq: a behavioural DSP48A1 slice (M, OPMODE, P and
// CARRYOUT registers) closes the loop; jobs come from a vector table plus a
// few hand-written sequences for reset, empty jobs and ignored starts.
module tb_dsp_mac_seq;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             sub = 1'b0;
  logic             bias_en = 1'b0;
  logic [47:0]      bias = '0;
  logic             in_valid = 1'b0;
  logic [17:0]      in_a = '0;
  logic [17:0]      in_b = '0;
  logic             in_ready;
  logic [17:0]      dsp_a, dsp_b, dsp_d;
  logic [47:0]      dsp_c;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce, dsp_rst;
  logic             busy, carry, done;
  logic [47:0]      result;

  // slice model state
  logic [35:0] m_r;
  logic [7:0]  opm_r;
  logic [47:0] p_r;
  logic        co_r;

  always #5 clk = ~clk;

  dsp_mac_seq #(.LEN_W(LEN_W), .OP_LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .sub(sub),
    .bias_en(bias_en), .bias(bias), .in_valid(in_valid), .in_a(in_a),
    .in_b(in_b), .in_ready(in_ready), .dsp_a(dsp_a), .dsp_b(dsp_b),
    .dsp_c(dsp_c), .dsp_d(dsp_d), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_rst(dsp_rst), .dsp_p(p_r), .dsp_carryout(co_r), .busy(busy),
    .result(result), .carry(carry), .done(done)
  );

  // DSP48A1 post-adder: X from M (or 0), Z from 0/P/C, bit 7 selects Z - X.
  // CARRYOUT on subtract is the borrow.
  function automatic logic [48:0] slice_alu(input logic [7:0] op, input logic [35:0] m,
                                            input logic [47:0] c, input logic [47:0] p);
    logic [47:0] x, z;
    logic [48:0] r;
    x = (op[1:0] == 2'b01) ? {12'd0, m} : 48'd0;
    case (op[3:2])
      2'b10:   z = p;
      2'b11:   z = c;
      default: z = 48'd0;
    endcase
    if (op[7]) begin
      r[47:0] = z - x;
      r[48]   = (z < x);
    end else begin
      r = {1'b0, z} + {1'b0, x};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (dsp_rst) begin
      m_r <= '0; opm_r <= '0; p_r <= '0; co_r <= 1'b0;
    end else if (dsp_ce) begin
      m_r   <= dsp_a * dsp_b;
      opm_r <= dsp_opmode;
      {co_r, p_r} <= slice_alu(opm_r, m_r, dsp_c, p_r);
    end
  end

  typedef struct packed {
    logic [7:0]       n;
    logic             sb;
    logic             be;
    logic [47:0]      bv;
    logic [3:0][17:0] a;
    logic [3:0][17:0] b;
    logic [7:0]       gap_at;
    logic [7:0]       gap;
    logic             hs;
    logic [47:0]      res;
    logic             cy;
    logic [7:0]       dlat;
    logic [7:0]       op1;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] n, input logic sb, input logic be,
                              input logic [47:0] bv, input logic [71:0] as,
                              input logic [71:0] bs, input logic [7:0] gap_at,
                              input logic [7:0] gap, input logic hs,
                              input logic [47:0] res, input logic cy,
                              input logic [7:0] dlat, input logic [7:0] op1);
    vec_t v;
    v.n = n; v.sb = sb; v.be = be; v.bv = bv; v.a = as; v.b = bs;
    v.gap_at = gap_at; v.gap = gap; v.hs = hs; v.res = res; v.cy = cy;
    v.dlat = dlat; v.op1 = op1;
    return v;
  endfunction

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] oplog [64];
  vec_t       vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (cyc < 64) oplog[cyc] = dsp_opmode;
  endtask

  // Start a job in the current IDLE cycle (cycle 0) and return result,
  // carry and the cycle done was seen in (-1 if it never came).
  task automatic run_job(input vec_t v, output logic [47:0] r, output logic cy,
                         output int dl);
    @(posedge clk); #1;
    cyc = 0;
    for (int i = 0; i < 64; i++) oplog[i] = 8'hxx;
    start = 1'b1; len = v.n; sub = v.sb; bias_en = v.be; bias = v.bv;
    tick();
    start = v.hs; len = '0;
    for (int i = 0; i < int'(v.n); i++) begin
      if (v.gap != 0 && i == int'(v.gap_at)) begin
        in_valid = 1'b0;
        repeat (int'(v.gap)) tick();
      end
      in_valid = 1'b1; in_a = v.a[i]; in_b = v.b[i];
      chk("in_ready_run", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0; in_a = '0; in_b = '0;
    while (!done && cyc < 40) tick();
    dl = done ? cyc : -1;
    r = result; cy = carry;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] r;
    logic        cy;
    int          dl;
    int          seen;
    logic [7:0]  seq0 [5];

    seq0[0] = 8'h01; seq0[1] = 8'h09; seq0[2] = 8'h09; seq0[3] = 8'h09; seq0[4] = 8'h08;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_carry", 64'(carry), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_dsp_a", 64'(dsp_a), 64'd0);
    chk("rst_dsp_c", 64'(dsp_c), 64'd0);
    chk("rst_opmode", 64'(dsp_opmode), 64'd0);
    chk("rst_ce", 64'(dsp_ce), 64'd1);
    chk("rst_dsp_rst", 64'(dsp_rst), 64'd1);
    rst = 1'b0;
    chk("dsp_rst_release", 64'(dsp_rst), 64'd1);
    @(posedge clk); #1;
    chk("dsp_rst_clear", 64'(dsp_rst), 64'd0);

    //            n  sb be bias     a (a3..a0)                       b (b3..b0)                       gat gap hs result                  cy dlat op1
    vecs[0] = mk(4, 0, 0, 48'd0,   {18'd4, 18'd3, 18'd2, 18'd1},   {18'd2, 18'd2, 18'd2, 18'd2},   0, 0, 0, 48'd20,                0, 8,  8'h01);
    vecs[1] = mk(4, 0, 0, 48'd0,   {18'd4, 18'd3, 18'd2, 18'd1},   {18'd2, 18'd2, 18'd2, 18'd2},   2, 2, 0, 48'd20,                0, 10, 8'h01);
    vecs[2] = mk(2, 1, 0, 48'd0,   {18'd0, 18'd0, 18'd2, 18'd3},   {18'd0, 18'd0, 18'd2, 18'd5},   0, 0, 0, 48'hFFFF_FFFF_FFED,    0, 6,  8'h81);
    vecs[3] = mk(1, 0, 1, 48'd100, {18'd0, 18'd0, 18'd0, 18'd10},  {18'd0, 18'd0, 18'd0, 18'd10},  0, 0, 0, 48'd200,               0, 5,  8'h0D);
    vecs[4] = mk(1, 0, 0, 48'd0,   {54'd0, 18'h3FFFF},             {54'd0, 18'h3FFFF},             0, 0, 0, 48'h000F_FFF8_0001,    0, 5,  8'h01);
    vecs[5] = mk(1, 1, 1, 48'd50,  {18'd0, 18'd0, 18'd0, 18'd3},   {18'd0, 18'd0, 18'd0, 18'd4},   0, 0, 0, 48'd38,                0, 5,  8'h8D);
    vecs[6] = mk(1, 0, 1, 48'hFFFF_FFFF_FFFF, {54'd0, 18'd1},      {54'd0, 18'd1},                 0, 0, 0, 48'd0,                 1, 5,  8'h0D);
    vecs[7] = mk(1, 1, 0, 48'd0,   {54'd0, 18'd1},                 {54'd0, 18'd1},                 0, 0, 0, 48'hFFFF_FFFF_FFFF,    1, 5,  8'h81);
    vecs[8] = mk(2, 0, 0, 48'd0,   {18'd0, 18'd0, 18'd1, 18'd5},   {18'd0, 18'd0, 18'd1, 18'd5},   0, 0, 1, 48'd26,                0, 6,  8'h01);

    for (int k = 0; k < 9; k++) begin
      run_job(vecs[k], r, cy, dl);
      chk($sformatf("v%0d_result", k), 64'(r), 64'(vecs[k].res));
      chk($sformatf("v%0d_carry", k), 64'(cy), 64'(vecs[k].cy));
      chk($sformatf("v%0d_done_cycle", k), 64'(dl), 64'(vecs[k].dlat));
      chk($sformatf("v%0d_first_opmode", k), 64'(oplog[2]), 64'(vecs[k].op1));
      if (k == 0)
        for (int j = 0; j < 5; j++)
          chk($sformatf("v0_opmode_c%0d", j + 2), 64'(oplog[j + 2]), 64'(seq0[j]));
      if (k == 1) begin
        chk("v1_bubble_opmode_c4", 64'(oplog[4]), 64'h08);
        chk("v1_bubble_opmode_c5", 64'(oplog[5]), 64'h08);
      end
      if (vecs[k].hs) begin
        tick(); tick();
        chk($sformatf("v%0d_start_ignored_busy", k), 64'(busy), 64'd0);
        chk($sformatf("v%0d_start_ignored_result", k), 64'(result), 64'(vecs[k].res));
      end
    end

    // rst in RUN after two of four pairs
    @(posedge clk); #1;
    start = 1'b1; len = 8'd4; sub = 1'b0; bias_en = 1'b0; bias = 48'h1234;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_a = 18'd1; in_b = 18'd2; tick();
    in_a = 18'd2; in_b = 18'd2; tick();
    in_a = 18'd3; in_b = 18'd2;
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_dsp_a", 64'(dsp_a), 64'd0);
    chk("midrst_dsp_c", 64'(dsp_c), 64'd0);
    chk("midrst_opmode", 64'(dsp_opmode), 64'd0);
    chk("midrst_dsp_rst", 64'(dsp_rst), 64'd1);
    in_valid = 1'b0; in_a = '0; in_b = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_dsp_rst_release", 64'(dsp_rst), 64'd1);
    seen = 0;
    tick();
    chk("midrst_dsp_rst_clear", 64'(dsp_rst), 64'd0);
    repeat (8) begin
      if (done) seen++;
      tick();
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    run_job(vecs[0], r, cy, dl);
    chk("after_rst_result", 64'(r), 64'd20);
    chk("after_rst_done_cycle", 64'(dl), 64'd8);

    // empty job
    @(posedge clk); #1;
    start = 1'b1; len = '0;
    chk("len0_in_ready_c0", 64'(in_ready), 64'd0);
    tick();
    start = 1'b0;
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_result", 64'(result), 64'd0);
    chk("len0_carry", 64'(carry), 64'd0);
    chk("len0_in_ready_c1", 64'(in_ready), 64'd0);
    tick();
    chk("len0_done_pulse", 64'(done), 64'd0);
    chk("len0_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
